mac_accumulator: RTL
====================

# mac_accumulator

Pipelined multiply-accumulate stage that sits directly downstream of the 16x16 unsigned array multiplier. It registers operand pairs, drives them through the array multiplier, and accumulates the 32-bit products into a wide accumulator over a frame delimited by a last flag. At frame end it presents the sum and term count through a valid/ready output register.

## Interface
- ACC_W, 40: accumulator and result width; must be at least 33.
- CNT_W, 16: term-counter width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  16  unsigned multiplicand
- in_b  in  16  unsigned multiplier
- in_last  in  1  beat is the final term of the frame
- out_valid  out  1  result held in output register
- out_ready  in  1  consumer takes the result
- out_acc  out  ACC_W  frame sum
- out_count  out  CNT_W  number of terms in the frame; saturates at all-ones
- out_ovf  out  1  frame sum exceeded 2^ACC_W-1

## Operation
- The pipeline advances when `adv = !(out_valid && !out_ready)`.
- `in_ready = adv`. It is combinational and carries no dependency on in_valid.
- **P1 (operand register):** on an `adv` edge, captures a_r, b_r, last1 and v1 from the inputs. v1 is set to `in_valid && in_ready`.
- **Multiply:** the array multiplier is combinational from a_r and b_r and gives an unsigned 32-bit product.
- **P2 (product register):** on an `adv` edge, captures prod_r, last2 and v2 from P1.
- **Accumulate:** on an `adv` edge with v2=1:
  - Compute `sum = acc + zero_extend(prod_r)` at ACC_W+1 bits.
  - The carry-out sets the frame overflow flag ovf_f, which is sticky for the frame.
  - cnt increments and saturates at 2^CNT_W-1.
- **Frame end (v2 && last2):**
  - out_acc, out_count and out_ovf load the final values, including the current term.
  - out_valid is set to 1.
  - acc, cnt and ovf_f clear to 0 on the same edge.
- **Accumulator FSM:**
  - IDLE: acc=0, no frame open. A v2 beat with last2=0 moves to RUN. A v2 beat with last2=1 emits a one-term result and stays in IDLE.
  - RUN: frame open. A v2 beat with last2=1 emits the result and moves to IDLE.
- **Output handshake:**
  - out_* stay stable while `out_valid && !out_ready`.
  - On an `out_valid && out_ready` edge, out_valid clears unless a new frame end loads on the same edge. In that case out_valid stays 1 and the new values load.
- All P1, P2 and accumulator state freezes while `adv=0`.

## Timing
- **Reset (asynchronous, rst_n=0):**
  - v1, v2, acc, cnt, ovf_f = 0; FSM = IDLE.
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - in_ready=1 immediately after reset releases.
- **Reset mid-frame:** the partial frame and any held result are discarded. The next frame starts from 0.
- **Latency:** a last beat accepted on edge N gives out_valid=1 after edge N+2, with no stall in between.
- **Throughput:** one beat per cycle. A frame end on every beat with out_ready=1 gives out_valid=1 every cycle.
- **Backpressure:** in_ready falls in the same cycle that out_valid=1 and out_ready=0. No beat is lost or duplicated.
- **Bubbles:** in_valid=0 cycles insert v=0 bubbles and do not disturb acc.

## Configuration
- **MAC_SAT_EN defined:** on overflow, the accumulator clamps to 2^ACC_W-1 and remains clamped for the rest of the frame. out_ovf=1.
- **MAC_SAT_EN undefined:** the accumulator wraps modulo 2^ACC_W. out_ovf still reports the sticky carry-out.

## Test plan
- **Single term:** in_a=3, in_b=5, in_last=1, out_ready=1.
  - Expect out_valid after 3 edges with out_acc=15, out_count=1, out_ovf=0.
- **Four terms:** four beats of 0xFFFF x 0xFFFF, last on the 4th.
  - Expect out_acc=0x03_FFF8_0004 (17179344900), out_count=4, out_ovf=0.
- **Overflow:** 257 beats of 0xFFFF x 0xFFFF.
  - With MAC_SAT_EN: out_acc=0xFF_FFFF_FFFF, out_ovf=1, out_count=257.
  - Without MAC_SAT_EN: out_acc=0x00_FDFE_0101, out_ovf=1.
- **Backpressure:** result pending, out_ready=0 for 10 cycles, in_valid=1 with a new frame 2x7, 4x4 (last).
  - in_ready=0 throughout and out_acc held.
  - After out_ready=1, the next result is out_acc=30, out_count=2.
- **Reset mid-frame:**
  - Accept 100x100 with last=0, then pulse rst_n low for one cycle.
  - Then send 1x1 with last=1.
  - Expect out_acc=1, out_count=1, and out_valid=0 during reset.
- **Back-to-back frames:** last=1 on every beat (values 1..8 squared), out_ready=1.
  - Expect out_valid high for 8 consecutive cycles with out_acc sequence 1,4,9,...,64.

Source files
------------

// File: rtl/mac_accumulator.sv
//------------------------------------------------------------------------------
// mac_accumulator : two-stage operand/product pipeline feeding a frame
//                   accumulator with a valid/ready result register.
// Optional feature macro: MAC_SAT_EN (clamp accumulator on overflow).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [0:0]       c_IDLE    = 1'b0;
  localparam logic [0:0]       c_RUN     = 1'b1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;

  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic             r_last1;
  logic             r_v1;
  logic [31:0]      r_prod;
  logic             r_last2;
  logic             r_v2;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_ovf;

  logic             w_adv;
  logic             w_frame_end;
  logic [31:0]      w_pp [0:15];
  logic [31:0]      w_prod;
  logic [ACC_W-1:0] w_acc_base;
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_ovf_base;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_adv       = !(r_out_valid && !out_ready);
  assign in_ready    = w_adv;
  assign w_frame_end = w_adv && r_v2 && r_last2;

  // Array multiplier: one shifted partial-product row per multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pp_row
      assign w_pp[gi] = r_b[gi] ? ({16'b0, r_a} << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    w_prod = '0;
    for (int i = 0; i < 16; i++) begin
      w_prod = w_prod + w_pp[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else if (w_adv) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_v2) begin
      case (r_state)
        c_IDLE:  w_state_next = r_last2 ? c_IDLE : c_RUN;
        c_RUN:   w_state_next = r_last2 ? c_IDLE : c_RUN;
        default: w_state_next = c_IDLE;
      endcase
    end
  end

  // With no frame open, the new frame always starts from a clean base.
  always_comb begin
    w_acc_base = '0;
    w_cnt_base = '0;
    w_ovf_base = 1'b0;
    if (r_state == c_RUN) begin
      w_acc_base = r_acc;
      w_cnt_base = r_cnt;
      w_ovf_base = r_ovf;
    end
  end

  assign w_sum      = {1'b0, w_acc_base} + {{(ACC_W + 1 - 32){1'b0}}, r_prod};
  assign w_ovf_next = w_ovf_base | w_sum[ACC_W];
  assign w_cnt_next = (w_cnt_base == c_CNT_MAX) ? w_cnt_base : w_cnt_base + 1'b1;

`ifdef MAC_SAT_EN
  assign w_acc_next = w_ovf_next ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_last1 <= 1'b0;
      r_v1    <= 1'b0;
      r_prod  <= '0;
      r_last2 <= 1'b0;
      r_v2    <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_last1 <= in_last;
      r_v1    <= in_valid;
      r_prod  <= w_prod;
      r_last2 <= r_last1;
      r_v2    <= r_v1;
      if (r_v2) begin
        if (r_last2) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          r_ovf <= w_ovf_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_frame_end) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_acc_next;
      r_out_count <= w_cnt_next;
      r_out_ovf   <= w_ovf_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
